// File: rtl/mem_stage_pkg.sv
// Shared types for the MIPS MEM stage: register/HI-LO write bundles, memory op codes,
// FSM state constants and big-endian byte-enable patterns.
package mem_stage_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef logic reset_status_t;
   localparam reset_status_t RST_ENABLE = 1'b0;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] waddr;
      logic [DATA_W-1:0]     wdata;
   } reg_t;

   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
   } hilo_t;

   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LBU  = 4'd2,
      MEM_LH   = 4'd3,
      MEM_LHU  = 4'd4,
      MEM_LW   = 4'd5,
      MEM_SB   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SW   = 4'd8
   } mem_op_t;

   typedef logic [1:0] mem_state_t;
   localparam mem_state_t IDLE = 2'd0;
   localparam mem_state_t WAIT = 2'd1;
   localparam mem_state_t DONE = 2'd2;

   // Lane 0 (MSB) is the lowest byte address: patterns are shifted right by the offset
   localparam logic [3:0] BE_BYTE = 4'b1000;
   localparam logic [3:0] BE_HALF = 4'b1100;
   localparam logic [3:0] BE_WORD = 4'b1111;

   function automatic logic op_is_load(input mem_op_t op);
      return (op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW});
   endfunction

   function automatic logic op_is_store(input mem_op_t op);
      return (op inside {MEM_SB, MEM_SH, MEM_SW});
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane logic: byte enables, store replication, load extract/extend.
// MEM_ALIGN_CHECK_EN enables misalignment detection for halfword/word accesses.
module mem_lane_align
   import mem_stage_pkg::*;
(
   input  mem_op_t     i_op,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_sdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ldata,
   output logic        o_is_load,
   output logic        o_is_store,
   output logic        o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign o_is_load  = op_is_load(i_op);
   assign o_is_store = op_is_store(i_op);

   // Lane selection from the read word; halfwords look at addr[1] only
   always_comb begin
      w_byte = i_rdata[31:24];
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[31:24];
         2'd1:    w_byte = i_rdata[23:16];
         2'd2:    w_byte = i_rdata[15:8];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];
   end

   always_comb begin
      o_be    = 4'b0000;
      o_wdata = 32'h0;
      o_ldata = 32'h0;
      case (i_op)
         MEM_LB: begin
            o_be    = BE_BYTE >> i_addr_lo;
            o_ldata = {{24{w_byte[7]}}, w_byte};
         end
         MEM_LBU: begin
            o_be    = BE_BYTE >> i_addr_lo;
            o_ldata = {24'h0, w_byte};
         end
         MEM_LH: begin
            o_be    = BE_HALF >> {i_addr_lo[1], 1'b0};
            o_ldata = {{16{w_half[15]}}, w_half};
         end
         MEM_LHU: begin
            o_be    = BE_HALF >> {i_addr_lo[1], 1'b0};
            o_ldata = {16'h0, w_half};
         end
         MEM_LW: begin
            o_be    = BE_WORD;
            o_ldata = i_rdata;
         end
         MEM_SB: begin
            o_be    = BE_BYTE >> i_addr_lo;
            o_wdata = {4{i_sdata[7:0]}};
         end
         MEM_SH: begin
            o_be    = BE_HALF >> {i_addr_lo[1], 1'b0};
            o_wdata = {2{i_sdata[15:0]}};
         end
         MEM_SW: begin
            o_be    = BE_WORD;
            o_wdata = i_sdata;
         end
         default: ;
      endcase
   end

`ifdef MEM_ALIGN_CHECK_EN
   always_comb begin
      o_misalign = 1'b0;
      case (i_op)
         MEM_LH, MEM_LHU, MEM_SH: o_misalign = i_addr_lo[0];
         MEM_LW, MEM_SW:          o_misalign = |i_addr_lo;
         default:                 o_misalign = 1'b0;
      endcase
   end
`else
   assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: passes ALU results through and runs a stalling data-bus handshake for loads/stores.
// MEM_ALIGN_CHECK_EN turns misaligned halfword/word accesses into adel/ades instead of bus cycles.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 0
)(
   input  logic                  clk,
   input  reset_status_t         rst,
   input  reg_t                  mem_wreg_i,
   input  hilo_t                 mem_hilo_i,
   input  mem_op_t               mem_op_i,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [31:0]           mem_sdata_i,
   output reg_t                  mem_wreg_o,
   output hilo_t                 mem_hilo_o,
   output logic                  stall_req_o,
   output logic                  adel_o,
   output logic                  ades_o,
   output logic                  bus_err_o,
   output logic                  dbus_req_o,
   output logic                  dbus_we_o,
   output logic [ADDR_WIDTH-1:0] dbus_addr_o,
   output logic [3:0]            dbus_be_o,
   output logic [31:0]           dbus_wdata_o,
   input  logic                  dbus_ack_i,
   input  logic [31:0]           dbus_rdata_i
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   mem_state_t       r_state;
   mem_state_t       w_state_nxt;
   logic [31:0]      r_rdata;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             w_latch;
   logic             w_drive;
   logic             w_timeout;

   logic [3:0]       w_be;
   logic [31:0]      w_st_data;
   logic [31:0]      w_ld_data;
   logic             w_is_load;
   logic             w_is_store;
   logic             w_misalign;

   mem_lane_align u_lane (
      .i_op       (mem_op_i),
      .i_addr_lo  (mem_addr_i[1:0]),
      .i_sdata    (mem_sdata_i),
      .i_rdata    (r_rdata),
      .o_be       (w_be),
      .o_wdata    (w_st_data),
      .o_ldata    (w_ld_data),
      .o_is_load  (w_is_load),
      .o_is_store (w_is_store),
      .o_misalign (w_misalign)
   );

   // Counter holds WAIT cycles already spent; this cycle is the last one allowed
   assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                      (CNT_W'(r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         r_state <= IDLE;
         r_rdata <= 32'h0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
         if (w_latch) begin
            r_rdata <= dbus_rdata_i;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = '0;
      w_err_nxt    = 1'b0;
      w_latch      = 1'b0;
      w_drive      = 1'b0;
      mem_wreg_o   = '0;
      mem_hilo_o   = '0;
      stall_req_o  = 1'b0;
      adel_o       = 1'b0;
      ades_o       = 1'b0;
      bus_err_o    = 1'b0;
      dbus_req_o   = 1'b0;
      dbus_we_o    = 1'b0;
      dbus_addr_o  = '0;
      dbus_be_o    = 4'b0000;
      dbus_wdata_o = 32'h0;

      if (rst != RST_ENABLE) begin
         mem_hilo_o = mem_hilo_i;
         mem_wreg_o = mem_wreg_i;
         case (r_state)
            IDLE: begin
               if (mem_op_i != MEM_NONE) begin
                  mem_wreg_o.we = 1'b0;
                  if (w_misalign) begin
                     adel_o = w_is_load;
                     ades_o = w_is_store;
                  end else begin
                     w_drive = 1'b1;
                     if (dbus_ack_i) begin
                        w_latch     = 1'b1;
                        w_state_nxt = DONE;
                     end else begin
                        w_state_nxt = WAIT;
                     end
                  end
               end
            end
            WAIT: begin
               mem_wreg_o.we = 1'b0;
               w_drive       = 1'b1;
               if (dbus_ack_i) begin
                  w_latch     = 1'b1;
                  w_state_nxt = DONE;
               end else if (w_timeout) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = DONE;
               end else begin
                  w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
               end
            end
            DONE: begin
               w_state_nxt = IDLE;
               bus_err_o   = r_err;
               if (r_err || w_is_store) begin
                  mem_wreg_o.we = 1'b0;
               end else if (w_is_load) begin
                  mem_wreg_o.wdata = w_ld_data;
               end
            end
            default: w_state_nxt = IDLE;
         endcase

         // Bus fields follow the EX/MEM inputs, which the stall keeps frozen
         if (w_drive) begin
            stall_req_o  = 1'b1;
            dbus_req_o   = 1'b1;
            dbus_we_o    = w_is_store;
            dbus_addr_o  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
            dbus_be_o    = w_be;
            dbus_wdata_o = w_st_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a lane-arithmetic reference model.
// Honors MEM_ALIGN_CHECK_EN in the same way as the design build.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int unsigned T = 4;
`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   reset_status_t rst;
   reg_t          wreg_i, wreg_o;
   hilo_t         hilo_i, hilo_o;
   mem_op_t       op;
   logic [31:0]   addr, sdata, daddr, dwdata, rdata;
   logic          stall, adel, ades, berr, req, dwe, ack;
   logic [3:0]    be;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          obs_stall, obs_err;
   logic        obs_adel;
   logic [3:0]  obs_be;
   logic [31:0] obs_addr, obs_wd, obs_res;

   always #5 clk = ~clk;

   mem_stage #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_wreg_i   (wreg_i),
      .mem_hilo_i   (hilo_i),
      .mem_op_i     (op),
      .mem_addr_i   (addr),
      .mem_sdata_i  (sdata),
      .mem_wreg_o   (wreg_o),
      .mem_hilo_o   (hilo_o),
      .stall_req_o  (stall),
      .adel_o       (adel),
      .ades_o       (ades),
      .bus_err_o    (berr),
      .dbus_req_o   (req),
      .dbus_we_o    (dwe),
      .dbus_addr_o  (daddr),
      .dbus_be_o    (be),
      .dbus_wdata_o (dwdata),
      .dbus_ack_i   (ack),
      .dbus_rdata_i (rdata)
   );

   task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic int size_of(input mem_op_t o);
      case (o)
         MEM_LB, MEM_LBU, MEM_SB: return 1;
         MEM_LH, MEM_LHU, MEM_SH: return 2;
         MEM_LW, MEM_SW:          return 4;
         default:                 return 0;
      endcase
   endfunction

   function automatic bit is_ld(input mem_op_t o);
      return (o == MEM_LB) || (o == MEM_LBU) || (o == MEM_LH) || (o == MEM_LHU) || (o == MEM_LW);
   endfunction

   function automatic bit is_st(input mem_op_t o);
      return (o == MEM_SB) || (o == MEM_SH) || (o == MEM_SW);
   endfunction

   function automatic bit misaligned(input mem_op_t o, input logic [31:0] a);
      int s = size_of(o);
      return ALIGN_CHK && (s > 1) && ((int'(a % 32'd4) % s) != 0);
   endfunction

   // First byte lane touched (0 = lowest address = most significant byte)
   function automatic int lane0(input mem_op_t o, input logic [31:0] a);
      int s = size_of(o);
      int off = int'(a % 32'd4);
      if (s == 1) return off;
      if (s == 2) return (off / 2) * 2;
      return 0;
   endfunction

   function automatic logic [3:0] model_be(input mem_op_t o, input logic [31:0] a);
      logic [3:0] b = 4'b0000;
      int l = lane0(o, a);
      for (int i = 0; i < size_of(o); i++) b[3 - (l + i)] = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] model_store(input mem_op_t o, input logic [31:0] sd);
      case (size_of(o))
         1:       return (sd % 32'd256) * 32'h01010101;
         2:       return (sd % 32'd65536) * 32'h00010001;
         default: return sd;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input mem_op_t o, input logic [31:0] a, input logic [31:0] rd);
      int     s = size_of(o);
      int     l = lane0(o, a);
      longint v = longint'({32'h0, rd});
      if (s == 0) return 32'h0;
      v = (v >> (8 * (4 - l - s))) % (longint'(1) << (8 * s));
      if ((o == MEM_LB || o == MEM_LH) && v >= (longint'(1) << (8 * s - 1)))
         v = v - (longint'(1) << (8 * s));
      return 32'(v);
   endfunction

   // ---------------- stimulus tasks ----------------
   task automatic check_all_zero(input string tag);
      check({tag, "_wreg"},  80'(wreg_o), 80'(0));
      check({tag, "_hilo"},  80'(hilo_o), 80'(0));
      check({tag, "_ctl"},   80'({stall, adel, ades, berr, req, dwe}), 80'(0));
      check({tag, "_bus"},   80'({daddr, be, dwdata}), 80'(0));
   endtask

   task automatic do_none(input reg_t wr, input hilo_t hl);
      op = MEM_NONE; addr = $urandom(); sdata = $urandom();
      wreg_i = wr; hilo_i = hl;
      ack = 1'($urandom_range(0, 1)); rdata = $urandom();
      #1;
      check("none_wreg", 80'(wreg_o), 80'(wr));
      check("none_hilo", 80'(hilo_o), 80'(hl));
      check("none_ctl", 80'({stall, req, berr, adel, ades}), 80'(0));
      tick();
   endtask

   // ack_k: cycle index (0 = first cycle of the access) at which ack is raised
   task automatic do_access(input mem_op_t o, input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input int ack_k, input reg_t wr, input hilo_t hl);
      bit ld  = is_ld(o);
      bit st  = is_st(o);
      bit mis = misaligned(o, a);
      bit err = (ack_k > int'(T));
      int n_cyc = err ? int'(T) + 1 : ack_k + 1;
      obs_stall = 0; obs_err = 0;
      op = o; addr = a; sdata = sd; wreg_i = wr; hilo_i = hl;
      if (mis) begin
         ack = 1'b0; #1;
         check("mis_adel", 80'(adel), 80'(ld));
         check("mis_ades", 80'(ades), 80'(st));
         check("mis_ctl", 80'({req, stall}), 80'(0));
         check("mis_we", 80'(wreg_o.we), 80'(0));
         obs_adel = adel; obs_be = be; obs_addr = daddr; obs_wd = dwdata;
         tick();
         return;
      end
      for (int c = 0; c < n_cyc; c++) begin
         ack   = (c == ack_k);
         rdata = (c == ack_k) ? rd : $urandom();
         #1;
         if (c == 0) begin
            obs_adel = adel; obs_be = be; obs_addr = daddr; obs_wd = dwdata;
         end
         check("acc_stall", 80'(stall), 80'(1));
         check("acc_req", 80'(req), 80'(1));
         check("acc_dwe", 80'(dwe), 80'(st));
         check("acc_addr", 80'(daddr), 80'(a - (a % 32'd4)));
         check("acc_be", 80'(be), 80'(model_be(o, a)));
         if (st) check("acc_wdata", 80'(dwdata), 80'(model_store(o, sd)));
         check("acc_we", 80'(wreg_o.we), 80'(0));
         check("acc_berr", 80'(berr), 80'(0));
         if (stall) obs_stall++;
         if (berr) obs_err++;
         tick();
      end
      ack = 1'b0; #1;
      check("done_stall", 80'(stall), 80'(0));
      check("done_req", 80'(req), 80'(0));
      check("done_berr", 80'(berr), 80'(err));
      check("done_hilo", 80'(hilo_o), 80'(hl));
      check("done_we", 80'(wreg_o.we), 80'((ld && !err) ? wr.we : 1'b0));
      check("done_waddr", 80'(wreg_o.waddr), 80'(wr.waddr));
      if (ld && !err) check("done_wdata", 80'(wreg_o.wdata), 80'(model_load(o, a, rd)));
      if (stall) obs_stall++;
      if (berr) obs_err++;
      obs_res = wreg_o.wdata;
      tick();
   endtask

   function automatic reg_t rnd_wreg();
      reg_t r;
      r.we = 1'($urandom_range(0, 1)); r.waddr = 5'($urandom()); r.wdata = $urandom();
      return r;
   endfunction

   function automatic hilo_t rnd_hilo();
      hilo_t h;
      h.we = 1'($urandom_range(0, 1)); h.hi = $urandom(); h.lo = $urandom();
      return h;
   endfunction

   initial begin
      reg_t  wr;
      hilo_t hl;
      rst = RST_ENABLE;
      op = MEM_LW; addr = 32'h3002; sdata = 32'h5555AAAA; ack = 1'b1; rdata = 32'hFFFFFFFF;
      wreg_i = '{we: 1'b1, waddr: 5'd7, wdata: 32'h99}; hilo_i = '{we: 1'b1, hi: 32'h1, lo: 32'h2};
      tick(); tick();
      check_all_zero("reset");
      rst = ~RST_ENABLE;

      // ALU result passes through untouched
      wr = '{we: 1'b1, waddr: 5'd5, wdata: 32'h1234};
      hl = '{we: 1'b0, hi: 32'h0, lo: 32'h0};
      do_none(wr, hl);

      // LB/LBU, ack in the first cycle
      wr = '{we: 1'b1, waddr: 5'd9, wdata: 32'h0};
      do_access(MEM_LB, 32'h1001, 32'h0, 32'h11AA2233, 0, wr, hl);
      check("lb_be", 80'(obs_be), 80'(4'b0100));
      check("lb_stall_cycles", 80'(obs_stall), 80'(1));
      check("lb_result", 80'(obs_res), 80'(32'hFFFFFFAA));
      do_access(MEM_LBU, 32'h1001, 32'h0, 32'h11AA2233, 0, wr, hl);
      check("lbu_result", 80'(obs_res), 80'(32'h000000AA));

      // SH with ack after three WAIT cycles
      do_access(MEM_SH, 32'h2002, 32'hDEADBEEF, 32'h0, 3, wr, hl);
      check("sh_be", 80'(obs_be), 80'(4'b0011));
      check("sh_wdata", 80'(obs_wd), 80'(32'hBEEFBEEF));
      check("sh_stall_cycles", 80'(obs_stall), 80'(4));

      // No ack: timeout after T WAIT cycles
      do_access(MEM_LW, 32'h5000, 32'h0, 32'h0, 99, wr, hl);
      do_none(wr, hl);
      check("to_err_pulses", 80'(obs_err), 80'(1));
      check("to_stall_cycles", 80'(obs_stall), 80'(T + 1));

      // Misaligned word load
      do_access(MEM_LW, 32'h3002, 32'h0, 32'h01020304, 1, wr, hl);
`ifdef MEM_ALIGN_CHECK_EN
      check("lw3002_adel", 80'(obs_adel), 80'(1));
`else
      check("lw3002_be", 80'(obs_be), 80'(4'b1111));
      check("lw3002_addr", 80'(obs_addr), 80'(32'h3000));
`endif

      // Reset in the middle of WAIT, then a stray late ack
      op = MEM_LW; addr = 32'h4000; ack = 1'b0; wreg_i = wr;
      #1; check("rw_req", 80'(req), 80'(1));
      tick(); #0; check("rw_wait_stall", 80'(stall), 80'(1));
      tick();
      rst = RST_ENABLE; #1;
      check_all_zero("rst_wait");
      tick();
      check_all_zero("rst_held");
      rst = ~RST_ENABLE;
      do_none(wr, hl);
      check("late_ack_berr", 80'(berr), 80'(0));
      do_access(MEM_LW, 32'h4000, 32'h0, 32'hCAFEF00D, 0, wr, hl);
      check("post_rst_lw", 80'(obs_res), 80'(32'hCAFEF00D));

      // Random traffic
      for (int i = 0; i < 200; i++) begin
         mem_op_t o;
         o  = mem_op_t'(4'($urandom_range(0, 8)));
         wr = rnd_wreg();
         hl = rnd_hilo();
         if (o == MEM_NONE)
            do_none(wr, hl);
         else
            do_access(o, $urandom(), $urandom(), $urandom(), int'($urandom_range(0, 6)), wr, hl);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS MEM pipeline stage. Sits directly downstream of the EX/MEM pipeline register and feeds the MEM/WB register.
- For non-memory instructions it passes the register-write and HI/LO-write bundles through unchanged.
- For loads and stores it runs a data-bus handshake, generates big-endian byte enables and replicated store data, and sign- or zero-extends load data.
- It stalls the pipeline until the access completes, errors, or times out.

Parameters:
- ADDR_WIDTH, 32, data-bus address width.
- TIMEOUT_CYCLES, 0, maximum WAIT cycles before a bus error is declared; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1 (reset_status_t)  synchronous, active-low; RST_ENABLE = 1'b0; sampled on posedge clk.
- mem_wreg_i  in  reg_t  GPR write bundle (we, waddr, wdata) from EX/MEM.
- mem_hilo_i  in  hilo_t  HI/LO write bundle from EX/MEM.
- mem_op_i  in  mem_op_t  MEM_NONE/LB/LBU/LH/LHU/LW/SB/SH/SW.
- mem_addr_i  in  ADDR_WIDTH  effective address.
- mem_sdata_i  in  32  store data (rt).
- mem_wreg_o  out  reg_t  to MEM/WB.
- mem_hilo_o  out  hilo_t  to MEM/WB.
- stall_req_o  out  1  freeze PC through EX/MEM.
- adel_o / ades_o  out  1  misaligned load / store (only with MEM_ALIGN_CHECK_EN).
- bus_err_o  out  1  timeout error, one-cycle pulse.
- dbus_req_o  out  1  access request.
- dbus_we_o  out  1  1 = store.
- dbus_addr_o  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- dbus_be_o  out  4  byte enables.
- dbus_wdata_o  out  32  store data.
- dbus_ack_i  in  1  access complete.
- dbus_rdata_i  in  32  load data, valid with ack.

Behaviour:
- Reset
  - While rst==RST_ENABLE, all outputs are driven 0 combinationally.
  - State becomes IDLE, the latched read data clears to 0, and the timeout counter clears to 0 at the clock edge.
  - Reset mid-access abandons the access; a late ack is ignored.
- FSM states and transitions
  - IDLE, mem_op_i==MEM_NONE: mem_wreg_o=mem_wreg_i, mem_hilo_o=mem_hilo_i, stall_req_o=0, dbus_req_o=0. Zero latency.
  - IDLE, mem op present: dbus_req_o=1, stall_req_o=1, mem_wreg_o.we=0. If dbus_ack_i is high the same cycle, latch rdata and go to DONE; otherwise go to WAIT.
  - WAIT: hold dbus_req_o and all bus fields stable, stall_req_o=1, counter increments. On ack, latch rdata and go to DONE.
  - WAIT timeout: if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES without ack, pulse bus_err_o and go to DONE with wreg we=0.
  - DONE: stall_req_o=0, dbus_req_o=0, present the result, return to IDLE. Minimum access latency is one stall cycle.
- Pipeline control holds EX/MEM stable while stall_req_o=1.
- dbus_ack_i with no request outstanding is ignored.
- Byte lanes are big-endian (o = addr[1:0]).
  - SB/LB/LBU: be = 4'b1000 >> o; data from bits [31-8o -: 8].
  - SH/LH/LHU: o=0 gives be 1100 and bits [31:16]; o=2 gives be 0011 and bits [15:0].
  - SW/LW: be = 1111.
- Store data: SB drives {4{sdata[7:0]}}, SH drives {2{sdata[15:0]}}, SW drives sdata.
- Load result
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - The result is written to mem_wreg_o.wdata with we=mem_wreg_i.we and waddr passed through.
  - Stores force we=0.
  - mem_hilo_o always passes through, including in DONE.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - A misaligned access is one where LH/LHU/SH have addr[0]!=0, or LW/SW have addr[1:0]!=0.
  - Such an access skips the bus (no req, no stall), asserts adel_o or ades_o combinationally for that cycle, and forces wreg we=0.
- Not defined:
  - adel_o/ades_o are tied to 0.
  - Halfword accesses use addr[1] only; word accesses ignore addr[1:0].

Decomposition:
- project_types gains:
  - mem_op_t enum.
  - mem_state_t {IDLE, WAIT, DONE}.
  - BE_BYTE/BE_HALF/BE_WORD constants.
- reg_t, hilo_t and RST_ENABLE are reused.
- One sub-module, mem_lane_align: combinational byte-enable, store-replicate and load-extract/extend logic.

Test Plan:
- ADDU result, wreg {we=1,waddr=5,wdata=0x1234} with MEM_NONE → same bundle out the same cycle, stall_req_o=0, dbus_req_o=0.
- LB addr 0x1001, ack in the same cycle, rdata 0x11AA2233 → be=0100, one stall cycle, wdata=0xFFFFFFAA; LBU of the same access → 0x000000AA.
- SH addr 0x2002, sdata 0xDEADBEEF, ack after 3 WAIT cycles → be=0011, wdata 0xBEEFBEEF, stall high for 4 cycles, we=0.
- TIMEOUT_CYCLES=4 with no ack → bus_err_o pulses once, stall drops after DONE, we=0.
- LW addr 0x3002: with MEM_ALIGN_CHECK_EN → adel_o=1, no dbus_req, we=0; without it → be=1111, address 0x3000.
- rst low during WAIT → all outputs 0, state IDLE; a subsequent ack is ignored.
